// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock/tick divider: defaults, channel
// run state and the divisor clamp.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int DIV_DEFAULT   = 50000000;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // A zero divisor behaves as divide-by-one; 64 bits covers any CNT_W in use.
    function automatic logic [63:0] eff_div(input logic [63:0] div);
        return (div == 64'd0) ? 64'd1 : div;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running count, active/shadow divisor pair and
// registered clk_out/tick outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] pending_div;
    logic [CNT_W-1:0] eff;
    logic             at_tc;
    ch_state_t        state;

    // A ">=" compare lets a freshly lowered divisor end the period at once
    // instead of wrapping the counter.
    always_comb begin
        state = en ? CH_RUN : CH_IDLE;
        eff   = CNT_W'(eff_div(64'(active_div)));
        at_tc = (count >= (eff - CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            active_div  <= RST_DIV;
            pending_div <= RST_DIV;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_pending <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync) begin
                count   <= '0;
                clk_out <= 1'b0;
                if (div_pending) begin
                    active_div  <= pending_div;
                    div_pending <= 1'b0;
                end
            end else if (state == CH_RUN) begin
                if (at_tc) begin
                    count   <= '0;
                    tick    <= 1'b1;
                    clk_out <= ~clk_out;
                    if (div_pending) begin
                        active_div  <= pending_div;
                        div_pending <= 1'b0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (div_pending) begin
                active_div  <= pending_div;
                div_pending <= 1'b0;
            end
            // A write wins over any clear above, so it always stays pending.
            if (wr) begin
                pending_div <= wr_div;
                div_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable divider: write-address decode, sync
// fan-out and one clk_div_channel per output bit.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_pending
);

    logic              wr_ok;
    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel numbers select nothing.
    always_comb begin
        wr_ok  = wr_en && (32'(wr_ch) < 32'(NUM_CH));
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok && (32'(wr_ch) == 32'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en[g]),
            .sync        (sync),
            .wr          (wr_sel[g]),
            .wr_div      (wr_div),
            .clk_out     (clk_out[g]),
            .tick        (tick[g]),
            .div_pending (div_pending[g])
        );
    end

endmodule
